// File: rtl/program_feeder_pkg.sv
// Shared definitions for the program feeder: controller states, the bit
// positions of the CPU input bus and the instruction word layout.
package program_feeder_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_RESET_CPU = 3'd1,
    ST_RUN_SETUP = 3'd2,
    ST_RUN_EDGE  = 3'd3,
    ST_DONE      = 3'd4
  } feeder_state_e;

  // Instruction word fields: {reg1Addr, reg0Addr, opcode}
  localparam int OPC_W   = 2;
  localparam int REG_W   = 2;
  localparam int INSTR_W = OPC_W + 2 * REG_W;

  typedef logic [INSTR_W-1:0] instr_t;

  // cpu_in bit positions; the instruction word lands unchanged on [7:2]
  localparam int CPU_CLK_BIT = 0;
  localparam int CPU_RST_BIT = 1;
  localparam int INSTR_LSB   = 2;
  localparam int OPC_LSB     = INSTR_LSB;
  localparam int REG0_LSB    = OPC_LSB + OPC_W;
  localparam int REG1_LSB    = REG0_LSB + REG_W;
  localparam int CPU_IN_W    = INSTR_LSB + INSTR_W;

  // Step counter increment that sticks at its maximum instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/program_feeder_mem.sv
// feeder_mem: DEPTH x 6 program store, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module feeder_mem
  import program_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  instr_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output instr_t        rdata_o
);

  instr_t mem_q [DEPTH];

  // Write one instruction word per accepted load
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/program_feeder.sv
// program_feeder: collects a short program from a writer, then single-steps
// an external CPU through it by driving the CPU clock, reset and instruction
// fields, using the CPU's reported pc to pick each instruction.
// Optional feature macro: FEEDER_STALL_DETECT_EN -- also ends a run when the
// CPU pc stays unchanged over 4 consecutive fetches.
module program_feeder
  import program_feeder_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MAX_STEPS = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [5:0] load_data,
  output logic       load_ready,
  input  logic       run,
  input  logic [7:0] cpu_out,
  output logic [7:0] cpu_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] steps
);

  localparam int            AW          = $clog2(DEPTH);
  localparam int            PW          = AW + 1;
  localparam logic [PW-1:0] FULL_PTR    = PW'(DEPTH);
  localparam logic [7:0]    MAX_STEPS_L = 8'(MAX_STEPS);

  feeder_state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]    steps_q, steps_d;
  logic [1:0]    ph_q, ph_d;
  instr_t        instr_q, instr_d;

  logic          load_accept;
  instr_t        mem_rdata;
  logic [8:0]    prog_len9;
  logic          pc_in_prog;
  logic [7:0]    steps_inc;

`ifdef FEEDER_STALL_DETECT_EN
  logic [7:0]    prev_pc_q, prev_pc_d;
  logic          prev_vld_q, prev_vld_d;
  logic [2:0]    eq_cnt_q, eq_cnt_d;
  logic [2:0]    eq_cnt_nx;
`endif

  // Program store: written at wr_ptr while loading, read at the CPU pc
  feeder_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (load_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (load_data),
    .raddr_i (cpu_out[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  assign load_ready  = (state_q == ST_LOAD) && (wr_ptr_q != FULL_PTR);
  assign load_accept = load_ready && load_valid;
  // wr_ptr doubles as the program length; widen so the full 8-bit pc compares
  assign prog_len9   = 9'(wr_ptr_q);
  assign pc_in_prog  = ({1'b0, cpu_out} < prog_len9);
  assign steps_inc   = sat_inc8(steps_q);
  assign steps       = steps_q;

  // Next-state and output decode for the load / reset / step sequencer
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    steps_d  = steps_q;
    ph_d     = ph_q;
    instr_d  = instr_q;
    cpu_in   = '0;
    busy     = 1'b0;
    done     = 1'b0;
`ifdef FEEDER_STALL_DETECT_EN
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    eq_cnt_d   = eq_cnt_q;
    eq_cnt_nx  = '0;
`endif

    case (state_q)
      ST_LOAD: begin
        if (load_accept) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
        // A word offered together with run is part of the program
        if (run && ((wr_ptr_q != '0) || load_accept)) begin
          state_d = ST_RESET_CPU;
          steps_d = '0;
          ph_d    = '0;
        end
      end

      ST_RESET_CPU: begin
        // Two CPU clock pulses with CPU reset held high
        busy                = 1'b1;
        cpu_in[CPU_RST_BIT] = 1'b1;
        cpu_in[CPU_CLK_BIT] = ph_q[0];
        ph_d                = ph_q + 2'd1;
`ifdef FEEDER_STALL_DETECT_EN
        prev_vld_d = 1'b0;
        eq_cnt_d   = '0;
`endif
        if (ph_q == 2'd3) begin
          state_d = ST_RUN_SETUP;
        end
      end

      ST_RUN_SETUP: begin
        busy = 1'b1;
        if (!pc_in_prog) begin
          // pc ran past the loaded program: stop without another pulse
          state_d = ST_DONE;
        end else begin
          cpu_in[INSTR_LSB +: INSTR_W] = mem_rdata;
          instr_d                      = mem_rdata;
          state_d                      = ST_RUN_EDGE;
`ifdef FEEDER_STALL_DETECT_EN
          eq_cnt_nx  = (prev_vld_q && (cpu_out == prev_pc_q)) ? eq_cnt_q + 3'd1 : 3'd0;
          eq_cnt_d   = eq_cnt_nx;
          prev_pc_d  = cpu_out;
          prev_vld_d = 1'b1;
          if (eq_cnt_nx == 3'd4) begin
            state_d = ST_DONE;
          end
`endif
        end
      end

      ST_RUN_EDGE: begin
        busy                         = 1'b1;
        cpu_in[CPU_CLK_BIT]          = 1'b1;
        cpu_in[INSTR_LSB +: INSTR_W] = instr_q;
        steps_d                      = steps_inc;
        state_d                      = (steps_inc >= MAX_STEPS_L) ? ST_DONE : ST_RUN_SETUP;
      end

      ST_DONE: begin
        done = 1'b1;
        // Replay the same program from a fresh CPU reset
        if (run) begin
          state_d = ST_RESET_CPU;
          steps_d = '0;
          ph_d    = '0;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_LOAD;
      wr_ptr_q <= '0;
      steps_q  <= '0;
      ph_q     <= '0;
`ifdef FEEDER_STALL_DETECT_EN
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      eq_cnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      steps_q  <= steps_d;
      ph_q     <= ph_d;
`ifdef FEEDER_STALL_DETECT_EN
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      eq_cnt_q   <= eq_cnt_d;
`endif
    end
  end

  // Instruction held from fetch to pulse; pure data, no reset needed
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
  end

endmodule

// File: tb/tb_program_feeder.sv
// Testbench for program_feeder: a behavioural CPU answers the feeder's
// pulses with a pc, and a list-based reference model predicts the pulses.
module tb_program_feeder;

  localparam int DEPTH = 16;
  localparam int MAXS  = 5;
`ifdef FEEDER_STALL_DETECT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    int len;
    int mode;
    int exp_pulses;
    int exp_steps;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [5:0] load_data;
  logic       load_ready;
  logic       run;
  logic [7:0] cpu_out;
  logic [7:0] cpu_in;
  logic       busy;
  logic       done;
  logic [7:0] steps;

  program_feeder #(.DEPTH(DEPTH), .MAX_STEPS(MAXS)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .run        (run),
    .cpu_out    (cpu_out),
    .cpu_in     (cpu_in),
    .busy       (busy),
    .done       (done),
    .steps      (steps)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural CPU: reset pulse -> pc 0; run pulse -> log instruction, move pc
  int         cpu_mode = 0;   // 0 counting, 1 stuck, 2 scripted jumps
  int         jump_tbl [64];
  logic [7:0] pc = 8'd0;
  logic [5:0] pulse_log [$];

  assign cpu_out = pc;

  always @(posedge clk) begin
    if (cpu_in[0]) begin
      if (cpu_in[1]) begin
        pc <= 8'd0;
      end else begin
        case (cpu_mode)
          0:       pc <= pc + 8'd1;
          1:       pc <= pc;
          default: pc <= 8'(jump_tbl[pulse_log.size() % 64]);
        endcase
        pulse_log.push_back(cpu_in[7:2]);
      end
    end
  end

  // Reference model state
  logic [5:0] prog_w [DEPTH];
  int         prog_len = 0;
  logic [5:0] exp_q [$];
  int         exp_steps;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Walk the program as the CPU would be stepped through it
  task automatic build_expected();
    int p    = 0;
    int n    = 0;
    int prev = -1;
    int eq   = 0;
    exp_q.delete();
    for (int guard = 0; guard < 1000; guard++) begin
      if (p >= prog_len) break;
      if (STALL_EN) begin
        eq   = (p == prev) ? eq + 1 : 0;
        prev = p;
        if (eq >= 4) break;
      end
      exp_q.push_back(prog_w[p]);
      n++;
      if (n >= MAXS) break;
      if (cpu_mode == 0)      p = p + 1;
      else if (cpu_mode == 2) p = jump_tbl[(n - 1) % 64];
    end
    exp_steps = n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0; run = 1'b0; load_data = '0;
    @(negedge clk);
    rst = 1'b1;
    prog_len = 0;
  endtask

  task automatic load_word(input logic [5:0] w);
    load_valid = 1'b1;
    load_data  = w;
    chk("load_ready while loading", int'(load_ready), 1);
    @(negedge clk);
    load_valid = 1'b0;
    prog_w[prog_len] = w;
    prog_len++;
  endtask

  // Start a run (optionally with a word offered the same cycle) and check it
  task automatic run_and_check(input string nm, input bit simul, input logic [5:0] w);
    bit got_done;
    pulse_log.delete();
    run = 1'b1;
    if (simul) begin
      load_valid = 1'b1;
      load_data  = w;
      prog_w[prog_len] = w;
      prog_len++;
    end
    build_expected();
    @(negedge clk);
    run = 1'b0;
    load_valid = 1'b0;
    chk({nm, " busy in reset"}, int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      chk({nm, " cpu_in[1:0] seq"}, int'(cpu_in[1:0]), (i == 4) ? 0 : ((i % 2 == 0) ? 2 : 3));
      if (i < 4) chk({nm, " steps in reset"}, int'(steps), 0);
      @(negedge clk);
    end
    got_done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({nm, " done reached"}, int'(got_done), 1);
    chk({nm, " pulse count"}, pulse_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < pulse_log.size(); k++)
      chk($sformatf("%s instr[%0d]", nm, k), int'(pulse_log[k]), int'(exp_q[k]));
    chk({nm, " steps"}, int'(steps), exp_steps);
    chk({nm, " cpu_in in done"}, int'(cpu_in), 0);
    chk({nm, " busy in done"}, int'(busy), 0);
  endtask

  initial begin
    vec_t tbl [5];
    int   acc;
    bit   seen;
    int   len;

    rst = 1'b1; load_valid = 1'b0; load_data = '0; run = 1'b0;

    tbl[0] = '{3, 0, 3, 3};
    tbl[1] = '{8, 0, 5, 5};
    tbl[2] = '{1, 0, 1, 1};
    tbl[3] = '{4, 1, STALL_EN ? 4 : 5, STALL_EN ? 4 : 5};
    tbl[4] = '{16, 0, 5, 5};

    // Reset state
    do_reset();
    chk("reset load_ready", int'(load_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset steps", int'(steps), 0);
    chk("reset cpu_in", int'(cpu_in), 0);

    // run with nothing loaded is ignored
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("empty run busy", int'(busy), 0);
    chk("empty run load_ready", int'(load_ready), 1);

    // Table-driven scenarios
    for (int t = 0; t < 5; t++) begin
      do_reset();
      cpu_mode = tbl[t].mode;
      for (int i = 0; i < tbl[t].len; i++) load_word(6'($urandom));
      run_and_check($sformatf("vec%0d", t), 1'b0, 6'd0);
      chk($sformatf("vec%0d table pulses", t), pulse_log.size(), tbl[t].exp_pulses);
      chk($sformatf("vec%0d table steps", t), int'(steps), tbl[t].exp_steps);
    end

    // Replay from DONE with the same program
    run_and_check("replay", 1'b0, 6'd0);
    chk("replay pulses", pulse_log.size(), 5);

    // Hold load_valid for 20 cycles: exactly DEPTH words accepted
    do_reset();
    cpu_mode = 0;
    acc = 0;
    for (int c = 1; c <= 20; c++) begin
      load_valid = 1'b1;
      load_data  = 6'(c);
      if (c >= 17) chk($sformatf("fill load_ready cycle %0d", c), int'(load_ready), 0);
      if (load_ready) begin
        prog_w[prog_len] = 6'(c);
        prog_len++;
        acc++;
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    chk("fill words accepted", acc, DEPTH);
    run_and_check("fill run", 1'b0, 6'd0);

    // Word offered in the same cycle as run counts toward the program
    do_reset();
    cpu_mode = 0;
    run_and_check("simul", 1'b1, 6'h2D);
    chk("simul pulses", pulse_log.size(), 1);

    // Reset while a CPU pulse is being driven
    do_reset();
    cpu_mode = 0;
    for (int i = 0; i < 8; i++) load_word(6'($urandom));
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (cpu_in[1:0] == 2'b01) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midrun reached pulse", int'(seen), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    prog_len = 0;
    chk("midrun rst cpu_in", int'(cpu_in), 0);
    chk("midrun rst steps", int'(steps), 0);
    chk("midrun rst load_ready", int'(load_ready), 1);
    chk("midrun rst busy", int'(busy), 0);
    chk("midrun rst done", int'(done), 0);

    // Randomized programs and pc behaviour against the model
    for (int r = 0; r < 8; r++) begin
      do_reset();
      len      = int'($urandom_range(1, DEPTH));
      cpu_mode = int'($urandom_range(0, 2));
      for (int j = 0; j < 64; j++) jump_tbl[j] = int'($urandom_range(0, len + 1));
      for (int i = 0; i < len; i++) load_word(6'($urandom));
      run_and_check($sformatf("rand%0d", r), 1'b0, 6'd0);
      if (r % 2 == 1) run_and_check($sformatf("rand%0d replay", r), 1'b0, 6'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_feeder.md
PROGRAM_FEEDER -- requirements
Module: program_feeder

Interface
REQ-001 Parameter DEPTH, default 16: program memory entries, power of two, 2..256.
REQ-002 Parameter MAX_STEPS, default 255: CPU clock pulses issued before forced stop.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 load_valid  input  1  writer offers one instruction word.
REQ-006 load_data  input  6  instruction {reg1Addr[1:0], reg0Addr[1:0], opcode[1:0]}.
REQ-007 load_ready  output  1  feeder accepts load_data this cycle.
REQ-008 run  input  1  start execution of the loaded program.
REQ-009 cpu_out  input  8  CPU out bus (pc when CPU output select is 0).
REQ-010 cpu_in  output  8  CPU in bus: [0]=cpu clk, [1]=cpu rst (active-high), [3:2]=opcode, [5:4]=reg0Addr, [7:6]=reg1Addr.
REQ-011 busy  output  1  high in RESET_CPU and RUN states.
REQ-012 done  output  1  high in DONE state.
REQ-013 steps  output  8  CPU clock pulses issued since run accepted.

Function
REQ-014 States: LOAD, RESET_CPU, RUN_SETUP, RUN_EDGE, DONE.
REQ-015 LOAD: load_ready=1; on load_valid&load_ready, mem[wr_ptr]<=load_data and wr_ptr increments; prog_len=wr_ptr.
REQ-016 load_ready SHALL drop to 0 when wr_ptr==DEPTH; further load_valid is ignored, no wrap.
REQ-017 LOAD with run=1 and prog_len>0 goes to RESET_CPU; run with prog_len==0 is ignored.
REQ-018 Simultaneous load_valid and run in LOAD: the word is written first and counts toward prog_len.
REQ-019 RESET_CPU lasts exactly 2 pulses: cpu_in[1]=1, cpu_in[0] driven 0,1,0,1 over 4 cycles, instruction field 0; steps stays 0.
REQ-020 RUN_SETUP: cpu_in[0]=0, cpu_in[1]=0, cpu_in[7:2]=mem[cpu_out[log2(DEPTH)-1:0]], one cycle, then RUN_EDGE.
REQ-021 RUN_EDGE: cpu_in[0]=1, instruction field held from RUN_SETUP, steps increments (saturating at 255), then RUN_SETUP.
REQ-022 In RUN_SETUP, cpu_out>=prog_len SHALL go to DONE without issuing a pulse.
REQ-023 In RUN_EDGE, steps reaching MAX_STEPS SHALL go to DONE after that pulse.
REQ-024 DONE: cpu_in=0, done=1; run=1 returns to RESET_CPU with the same program, steps cleared.
REQ-025 Program memory is not cleared by DONE or run; only rst clears wr_ptr.

Reset
REQ-026 rst=0 at any clock edge, including mid-RUN: state=LOAD, wr_ptr=0, steps=0, cpu_in=8'h00, busy=0, done=0, load_ready=1 on the following cycle.
REQ-027 Memory contents are not reset; only entries below wr_ptr are observable.

Configuration
REQ-028 Macro FEEDER_STALL_DETECT_EN: when defined, RUN_SETUP compares cpu_out with the pc sampled at the previous RUN_SETUP, and 4 consecutive equal samples SHALL go to DONE.
REQ-029 Without FEEDER_STALL_DETECT_EN, no comparison logic exists and only REQ-022/REQ-023 end a run.

Structure
REQ-030 Shared package holds the state enumeration, the cpu_in bit-position constants and the instruction field widths.
REQ-031 One sub-module feeder_mem: DEPTH x 6 register array, one write port, one asynchronous read port.

Verification
REQ-032 Load 3 words, run, with cpu_out modelled as a 0,1,2,3 counter -> exactly 3 pulses with cpu_in[7:2] = words 0,1,2, then done=1 and steps=3.
REQ-033 Hold load_valid for 20 cycles with DEPTH=16 -> 16 words accepted, load_ready=0 from cycle 17.
REQ-034 After run, observe the first 4 cycles -> cpu_in[1:0] sequence 2'b10,2'b11,2'b10,2'b11, then 2'b00.
REQ-035 cpu_out held at 0 with MAX_STEPS=5 and macro undefined -> done after 5 pulses, steps=5; macro defined -> done after 4 pulses.
REQ-036 rst=0 asserted during RUN_EDGE -> next cycle cpu_in=8'h00, state LOAD, steps=0, load_ready=1.
REQ-037 run=1 in DONE -> new RESET_CPU sequence and the same program replayed, steps restarting at 0.
